rotary_speed_select: RTL and testbench
======================================

// Module: rotary_speed_select
// PURPOSE
//  Upstream stage of the LED sweep: decodes a mechanical quadrature rotary encoder into an
//  8-level speed index and drives the 8-bit counter_offset bus that picks the divider tap bit.
//  Inputs are synchronised and debounced, and each full detent is decoded. CW detents step
//  faster and CCW detents step slower. The index saturates at both ends and never wraps.
// PARAMETERS
//  DEBOUNCE_CYCLES    50000  clocks a synced input must be stable before it is accepted (1 ms @ 50 MHz)
//  COUNTS_PER_DETENT  4      valid quadrature transitions that make one detent (allowed: 1, 2 or 4)
//  NUM_STEPS          8      number of speed levels; speed_idx runs 0..NUM_STEPS-1
//  OFFSET_SLOW        25     counter_offset at speed_idx 0; must be >= NUM_STEPS-1
// PORTS
//  CLOCK_50        in   1  system clock, 50 MHz
//  reset           in   1  asynchronous, active-high
//  enc_a           in   1  encoder channel A, asynchronous and bouncy
//  enc_b           in   1  encoder channel B, asynchronous and bouncy
//  counter_offset  out  8  divider tap select = OFFSET_SLOW - speed_idx
//  speed_idx       out  3  current speed level; 0 = slowest
//  step_up         out  1  1-cycle pulse when speed_idx increments
//  step_dn         out  1  1-cycle pulse when speed_idx decrements
//  quad_error      out  1  1-cycle pulse on an illegal transition (both channels change at once)
// BEHAVIOUR
//  Reset values: speed_idx=0, counter_offset=OFFSET_SLOW (25), step_up=step_dn=quad_error=0.
//  Reset also clears internals: sync flops=0, debounce counters=0, sub_cnt=0, FSM=INIT.
//  Reset asserted mid-detent discards the partial count. A pending debounce is also discarded.
//  Sync: two-flop synchroniser per channel.
//  Debounce, per channel: while synced != filtered, count up; otherwise hold the counter at 0.
//   When the counter reaches DEBOUNCE_CYCLES-1, load filtered <= synced and clear the counter.
//   A glitch shorter than DEBOUNCE_CYCLES never reaches filtered.
//  FSM INIT: after reset, filtered is loaded unconditionally on the first DEBOUNCE_CYCLES-stable
//   sample, whatever its value. prev <= {A,B}, then go to RUN. No counting and no error in INIT.
//  FSM RUN: evaluate {A,B} against prev on every clock edge; prev <= {A,B} on every edge.
//   CW sequence 00->01->11->10->00: sub_cnt += 1. The reverse sequence: sub_cnt -= 1.
//   Unchanged: hold. Both bits changed: quad_error=1 for one cycle, sub_cnt <= 0.
//  sub_cnt is signed, 4 bits.
//   On reaching +COUNTS_PER_DETENT: sub_cnt <= 0. If speed_idx < NUM_STEPS-1, speed_idx += 1
//   and step_up pulses; otherwise speed_idx holds and no pulse is issued.
//   On reaching -COUNTS_PER_DETENT: mirror case, with a floor of 0 and the step_dn pulse.
//   A direction reversal mid-detent walks sub_cnt back toward 0; no step occurs.
//  Latency: counter_offset, speed_idx and the pulses update on the edge after the filtered change
//   that completes the detent. Raw edge to output is 2 sync + DEBOUNCE_CYCLES + 1 clocks.
//  counter_offset is registered and updated in the same cycle as speed_idx; 8-bit subtraction, no underflow.
//  step_up and step_dn are never high together. quad_error and a step pulse are mutually exclusive.
// TESTING
//  1 Reset with A=B=1 held, then release -> INIT loads 11 with no error; counter_offset=25, speed_idx=0.
//  2 One clean CW detent (4 transitions, each stable 60000 clk) -> step_up 1 cycle; speed_idx=1, offset=24.
//  3 10 CW detents -> speed_idx=7, offset=18 after 7 steps; 3 further detents give no step_up and no change.
//  4 From speed_idx=7, CCW detents -> offset 19..25; at 0 an extra CCW gives no step_dn and no wrap.
//  5 A toggling with 100-clk bounce bursts, then stable -> exactly one filtered edge per settle.
//    Bounce alone with DEBOUNCE_CYCLES unmet -> no sub_cnt change.
//  6 Partial CW (2 transitions), then 2 CCW -> no step. Then force 00->11 -> quad_error 1 cycle, sub_cnt=0.
//    Then assert reset mid-detent -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rotary_speed_select.sv
// rotary_speed_select: debounced quadrature decoder driving a saturating speed index and divider tap offset.
module rotary_speed_select #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int COUNTS_PER_DETENT = 4,
    parameter int NUM_STEPS         = 8,
    parameter int OFFSET_SLOW       = 25
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         enc_a,
    input  logic                         enc_b,
    output logic [7:0]                   counter_offset,
    output logic [$clog2(NUM_STEPS)-1:0] speed_idx,
    output logic                         step_up,
    output logic                         step_dn,
    output logic                         quad_error
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IW = $clog2(NUM_STEPS);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0] DET = 4'(COUNTS_PER_DETENT);
    localparam logic [IW-1:0] TOP = IW'(NUM_STEPS - 1);

    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_n;
    logic [1:0] sync1, sync2, filt, filt_n, prev, prev_n, g_cur, g_prev;
    logic [CW-1:0] cnt_a, cnt_b, cnt_a_n, cnt_b_n, init_cnt, init_cnt_n;
    logic signed [3:0] sub_cnt, sub_n, sub_step;
    logic [IW-1:0] idx_n;
    logic up_n, dn_n, err_n, cw, ccw, load, chg_a, chg_b;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1          <= '0;
            sync2          <= '0;
            filt           <= '0;
            prev           <= '0;
            cnt_a          <= '0;
            cnt_b          <= '0;
            init_cnt       <= '0;
            sub_cnt        <= '0;
            state          <= INIT;
            speed_idx      <= '0;
            counter_offset <= 8'(OFFSET_SLOW);
            step_up        <= 1'b0;
            step_dn        <= 1'b0;
            quad_error     <= 1'b0;
        end else begin
            sync1          <= {enc_a, enc_b};
            sync2          <= sync1;
            filt           <= filt_n;
            prev           <= prev_n;
            cnt_a          <= cnt_a_n;
            cnt_b          <= cnt_b_n;
            init_cnt       <= init_cnt_n;
            sub_cnt        <= sub_n;
            state          <= state_n;
            speed_idx      <= idx_n;
            counter_offset <= 8'(OFFSET_SLOW) - 8'(idx_n);
            step_up        <= up_n;
            step_dn        <= dn_n;
            quad_error     <= err_n;
        end
    end

    always_comb begin
        chg_a      = state == RUN && sync2[1] != filt[1];
        chg_b      = state == RUN && sync2[0] != filt[0];
        cnt_a_n    = chg_a ? (cnt_a == DB_LAST ? '0 : cnt_a + 1'b1) : '0;
        cnt_b_n    = chg_b ? (cnt_b == DB_LAST ? '0 : cnt_b + 1'b1) : '0;
        // INIT accepts whatever level has been stable long enough, without decoding it
        load       = state == INIT && sync2 == prev && init_cnt == DB_LAST;
        init_cnt_n = (state == INIT && sync2 == prev && !load) ? init_cnt + 1'b1 : '0;
        state_n    = load ? RUN : state;
        filt_n     = state == INIT ? (load ? sync2 : filt)
                   : {chg_a && cnt_a == DB_LAST ? sync2[1] : filt[1],
                      chg_b && cnt_b == DB_LAST ? sync2[0] : filt[0]};
        prev_n     = state == INIT ? sync2 : filt;
        // Gray position: 00=0, 01=1, 11=2, 10=3; CW advances by one
        g_cur      = {filt[1], ^filt};
        g_prev     = {prev[1], ^prev};
        cw         = state == RUN && g_cur == g_prev + 2'd1;
        ccw        = state == RUN && g_prev == g_cur + 2'd1;
        err_n      = state == RUN && filt == ~prev;
        sub_step   = cw ? sub_cnt + 4'sd1 : ccw ? sub_cnt - 4'sd1 : sub_cnt;
        up_n       = sub_step == DET && speed_idx != TOP;
        dn_n       = sub_step == -DET && speed_idx != '0;
        sub_n      = (err_n || sub_step == DET || sub_step == -DET) ? 4'sd0 : sub_step;
        idx_n      = up_n ? speed_idx + 1'b1 : dn_n ? speed_idx - 1'b1 : speed_idx;
    end
endmodule

// File: tb/tb_rotary_speed_select.sv
// tb_rotary_speed_select: directed encoder stimulus checked every cycle against a detent-level model.
module tb_rotary_speed_select;
    localparam int DB = 8, C = 4, HOLD = 16;

    logic CLOCK_50 = 1'b0, reset = 1'b1, enc_a = 1'b1, enc_b = 1'b1;
    logic [7:0] counter_offset;
    logic [2:0] speed_idx;
    logic step_up, step_dn, quad_error;
    int checks = 0, errors = 0, ups = 0, dns = 0, errs = 0;
    logic [1:0] cur = 2'b11;

    always #5 CLOCK_50 = ~CLOCK_50;

    rotary_speed_select #(.DEBOUNCE_CYCLES(DB), .COUNTS_PER_DETENT(C), .NUM_STEPS(8), .OFFSET_SLOW(25)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .counter_offset(counter_offset), .speed_idx(speed_idx),
        .step_up(step_up), .step_dn(step_dn), .quad_error(quad_error)
    );

    function automatic int pos(input logic [1:0] x);
        return x == 2'b00 ? 0 : x == 2'b01 ? 1 : x == 2'b11 ? 2 : 3;
    endfunction

    function automatic logic [1:0] gray(input int p);
        return p == 0 ? 2'b00 : p == 1 ? 2'b01 : p == 2 ? 2'b11 : 2'b10;
    endfunction

    // Model: a level is accepted once DB consecutive synchronised samples disagree with the accepted one
    logic [1:0] h [0:DB+1];
    logic [1:0] mf, mp;
    int m_idx, m_sub, since, md;
    bit m_run, m_up, m_dn, m_err, mflip, mst;

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DB + 1; i++) h[i] = 2'b00;
            m_run = 0; since = 0; m_idx = 0; m_sub = 0;
            m_up = 0; m_dn = 0; m_err = 0; mf = 2'b00; mp = 2'b00;
        end else begin
            for (int i = DB + 1; i > 0; i--) h[i] = h[i-1];
            h[0] = {enc_a, enc_b};
            since++;
            m_up = 0; m_dn = 0; m_err = 0;
            if (m_run) begin
                md = (pos(mf) - pos(mp) + 4) % 4;
                if (md == 1) m_sub++;
                else if (md == 3) m_sub--;
                else if (md == 2) begin m_err = 1; m_sub = 0; end
                if (m_sub == C) begin
                    m_sub = 0;
                    if (m_idx < 7) begin m_idx++; m_up = 1; end
                end else if (m_sub == -C) begin
                    m_sub = 0;
                    if (m_idx > 0) begin m_idx--; m_dn = 1; end
                end
                mp = mf;
                for (int b = 0; b < 2; b++) begin
                    mflip = 1;
                    for (int i = 2; i <= DB + 1; i++) if (h[i][b] == mf[b]) mflip = 0;
                    if (mflip) mf[b] = ~mf[b];
                end
            end else if (since >= DB + 3) begin
                mst = 1;
                for (int i = 1; i <= DB + 1; i++) if (h[i] != h[0]) mst = 0;
                if (mst) begin m_run = 1; mf = h[0]; mp = h[0]; end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        checks++;
        if ({counter_offset, speed_idx, step_up, step_dn, quad_error} !==
            {8'(25 - m_idx), 3'(m_idx), m_up, m_dn, m_err}) begin
            errors++;
            $display("FAIL cycle t=%0t got off=%0d idx=%0d up=%b dn=%b err=%b want off=%0d idx=%0d up=%b dn=%b err=%b",
                     $time, counter_offset, speed_idx, step_up, step_dn, quad_error,
                     25 - m_idx, m_idx, m_up, m_dn, m_err);
        end
        ups  += int'(step_up);
        dns  += int'(step_dn);
        errs += int'(quad_error);
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input int n);
        @(negedge CLOCK_50);
        {enc_a, enc_b} = v;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic move(input int dir);
        cur = gray((pos(cur) + dir + 4) % 4);
        drive(cur, HOLD);
    endtask

    task automatic detent(input int dir);
        repeat (C) move(dir);
    endtask

    task automatic bouncy_move(input int dir);
        logic [1:0] nxt;
        nxt = gray((pos(cur) + dir + 4) % 4);
        repeat (3) begin
            drive(nxt, 2);
            drive(cur, 2);
        end
        cur = nxt;
        drive(cur, HOLD);
    endtask

    initial begin
        repeat (5) @(negedge CLOCK_50);
        lit("reset_offset", counter_offset, 25);
        lit("reset_idx", speed_idx, 0);
        lit("reset_pulses", {step_up, step_dn, quad_error}, 0);
        reset = 1'b0;
        repeat (40) @(negedge CLOCK_50);
        lit("init_idx", speed_idx, 0);
        lit("init_offset", counter_offset, 25);
        lit("init_no_error", errs, 0);

        detent(1);
        lit("cw1_idx", speed_idx, 1);
        lit("cw1_offset", counter_offset, 24);
        lit("cw1_ups", ups, 1);

        repeat (6) detent(1);
        lit("cw7_idx", speed_idx, 7);
        lit("cw7_offset", counter_offset, 18);
        repeat (3) detent(1);
        lit("cw_sat_ups", ups, 7);
        lit("cw_sat_idx", speed_idx, 7);

        repeat (7) detent(-1);
        lit("ccw_idx", speed_idx, 0);
        lit("ccw_offset", counter_offset, 25);
        lit("ccw_dns", dns, 7);
        detent(-1);
        lit("ccw_floor_dns", dns, 7);
        lit("ccw_floor_idx", speed_idx, 0);

        repeat (3) begin
            drive({~cur[1], cur[0]}, 2);
            drive(cur, 2);
        end
        drive(cur, HOLD);
        lit("bounce_only_idx", speed_idx, 0);
        lit("bounce_only_err", errs, 0);
        repeat (C) bouncy_move(1);
        lit("bounce_detent_idx", speed_idx, 1);
        lit("bounce_detent_ups", ups, 8);
        lit("bounce_detent_err", errs, 0);

        move(1); move(1); move(-1); move(-1);
        lit("reversal_idx", speed_idx, 1);
        lit("reversal_ups", ups, 8);
        move(1); move(1);
        cur = ~cur;
        drive(cur, HOLD);
        lit("quad_err_count", errs, 1);
        lit("quad_err_idx", speed_idx, 1);
        detent(1);
        lit("after_err_idx", speed_idx, 2);
        lit("after_err_ups", ups, 9);

        move(1); move(1);
        @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        lit("async_offset", counter_offset, 25);
        lit("async_idx", speed_idx, 0);
        lit("async_pulses", {step_up, step_dn, quad_error}, 0);
        repeat (3) @(negedge CLOCK_50);
        cur = 2'b11;
        {enc_a, enc_b} = cur;
        reset = 1'b0;
        repeat (40) @(negedge CLOCK_50);
        detent(1);
        lit("post_reset_idx", speed_idx, 1);
        lit("post_reset_offset", counter_offset, 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
